// File: rtl/cache_tag_ctrl_if.sv
// Bus bundle for the two-way cache tag controller: CPU request/response,
// tag store port, LRU store port and line-transfer handshake.
interface cache_tag_ctrl_if;
  // Requests follow valid/ready: a request transfers on a rising edge where
  // req_valid and req_ready are both high. resp_valid is a single-cycle pulse
  // with no back-pressure. mem_req is held until a one-cycle mem_ack pulse.
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;

  logic        resp_valid;
  logic        resp_hit;
  logic        resp_way;

  logic [8:0]  tag_addr;
  logic [1:0]  tag_we;
  logic [35:0] tag_din;
  logic [35:0] tag_dout;

  logic        lru_req;
  logic [8:0]  lru_addr;
  logic [1:0]  lru_hit;
  logic        lru_flag;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack;

  modport master (
    output req_valid, req_addr, req_we, tag_dout, lru_flag, mem_ack,
    input  req_ready, resp_valid, resp_hit, resp_way,
    input  tag_addr, tag_we, tag_din, lru_req, lru_addr, lru_hit,
    input  mem_req, mem_we, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, req_we, tag_dout, lru_flag, mem_ack,
    output req_ready, resp_valid, resp_hit, resp_way,
    output tag_addr, tag_we, tag_din, lru_req, lru_addr, lru_hit,
    output mem_req, mem_we, mem_addr
  );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Two-way set-associative tag controller: lookup, victim selection,
// dirty write-back, refill and tag/LRU update for one request at a time.
module cache_tag_ctrl #(
  parameter int WRITE_ALLOCATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  cache_tag_ctrl_if.slave  bus,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_REFILL = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_tag;
  logic [8:0]  r_index;
  logic        r_we;
  logic        r_victim;
  logic [15:0] r_vic_tag;

  logic [17:0] w_way_a;
  logic [17:0] w_way_b;
  logic        w_hit_a;
  logic        w_hit_b;
  logic        w_hit;
  logic        w_victim;
  logic [17:0] w_vic_entry;
  logic        w_vic_dirty;
  logic [17:0] w_new_entry;
  logic        w_no_alloc;

  // Entry layout per way: {valid, dirty, tag[15:0]}; way A in the upper half.
  assign w_way_a     = bus.tag_dout[35:18];
  assign w_way_b     = bus.tag_dout[17:0];
  assign w_hit_a     = w_way_a[17] && (w_way_a[15:0] == r_tag);
  assign w_hit_b     = w_way_b[17] && (w_way_b[15:0] == r_tag);
  assign w_hit       = w_hit_a || w_hit_b;

  // Fill empty ways first, A before B; otherwise the LRU store decides.
  assign w_victim    = !w_way_a[17] ? 1'b1 :
                       !w_way_b[17] ? 1'b0 : bus.lru_flag;
  assign w_vic_entry = w_victim ? w_way_a : w_way_b;
  assign w_vic_dirty = w_vic_entry[17] && w_vic_entry[16];

  // Store hits write {1,1,tag}; refill writes {1,we,tag}; both reduce to this.
  assign w_new_entry = {1'b1, r_we, r_tag};
  assign w_no_alloc  = r_we && (WRITE_ALLOCATE == 0);

  assign bus.lru_addr = r_index;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tag     <= '0;
      r_index   <= '0;
      r_we      <= 1'b0;
      r_victim  <= 1'b0;
      r_vic_tag <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_tag   <= bus.req_addr[31:16];
        r_index <= bus.req_addr[15:7];
        r_we    <= bus.req_we;
      end
      if (r_state == S_LOOKUP) begin
        r_victim  <= w_victim;
        r_vic_tag <= w_vic_entry[15:0];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_hit   = 1'b0;
    bus.resp_way   = 1'b0;
    bus.tag_addr   = r_index;
    bus.tag_we     = 2'b00;
    bus.tag_din    = {w_new_entry, w_new_entry};
    bus.lru_req    = 1'b0;
    bus.lru_hit    = 2'b00;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;

    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        // Address the tag store now so the entry is ready in LOOKUP.
        bus.tag_addr  = bus.req_addr[15:7];
        if (bus.req_valid) w_state_nxt = S_LOOKUP;
      end

      S_LOOKUP: begin
        if (w_hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_hit   = 1'b1;
          bus.resp_way   = w_hit_a;
          bus.lru_req    = 1'b1;
          bus.lru_hit    = {w_hit_a, w_hit_b};
          if (r_we) bus.tag_we = w_hit_a ? 2'b10 : 2'b01;
          w_state_nxt    = S_IDLE;
        end else if (w_no_alloc) begin
          bus.resp_valid = 1'b1;
          bus.resp_way   = w_victim;
          w_state_nxt    = S_IDLE;
        end else begin
          w_state_nxt    = w_vic_dirty ? S_WB : S_REFILL;
        end
      end

      S_WB: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {r_vic_tag, r_index, 7'b0};
        if (bus.mem_ack) w_state_nxt = S_REFILL;
      end

      S_REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {r_tag, r_index, 7'b0};
        if (bus.mem_ack) w_state_nxt = S_UPDATE;
      end

      S_UPDATE: begin
        bus.tag_we     = r_victim ? 2'b10 : 2'b01;
        bus.lru_req    = 1'b1;
        bus.lru_hit    = r_victim ? 2'b10 : 2'b01;
        bus.resp_valid = 1'b1;
        bus.resp_way   = r_victim;
        w_state_nxt    = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
